// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake/data bundle between a FIFO producer/consumer (master) and sync_fifo (slave)
//  master drives wr_en, rd_en, data_in; slave drives data_out, wr_ack, overflow, underflow,
//  full, almostfull, empty, almostempty.
interface sync_fifo_if #(parameter int FIFO_WIDTH = 16);
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, wr_ack, overflow, underflow, full, almostfull, empty, almostempty
  );
  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, wr_ack, overflow, underflow, full, almostfull, empty, almostempty
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of FIFO_DEPTH words of FIFO_WIDTH bits, async active-low reset
//  clk, rst_n : clock and asynchronous active-low reset
//  bus        : sync_fifo_if slave (write/read requests and data in; registered read data,
//               registered wr_ack/overflow/underflow pulses, combinational occupancy flags out)
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  sync_fifo_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  ack_q, ack_d, ovf_q, ovf_d, udf_q, udf_d;
  logic                  do_wr, do_rd;
  assign bus.full        = count_q == CW'(FIFO_DEPTH);
  assign bus.almostfull  = count_q == CW'(FIFO_DEPTH - 1);
  assign bus.empty       = count_q == '0;
  assign bus.almostempty = count_q == CW'(1);
  assign bus.data_out    = data_q;
  assign bus.wr_ack      = ack_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  // Pointers wrap by explicit compare so non-power-of-2 depths work.
  always_comb begin
    do_wr    = bus.wr_en & ~bus.full;
    do_rd    = bus.rd_en & ~bus.empty;
    wr_ptr_d = do_wr ? (wr_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = do_rd ? (rd_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    data_d   = do_rd ? mem_q[rd_ptr_q] : data_q;
    ack_d    = do_wr;
    ovf_d    = bus.wr_en & bus.full;
    udf_d    = bus.rd_en & bus.empty;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= bus.data_in;
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed bench for sync_fifo against a queue-based reference model
module tb_sync_fifo;
  localparam int W = 16;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sync_fifo_if #(.FIFO_WIDTH(W)) bus ();
  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  logic m_ack = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ack = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask
  // One clock: drive at negedge, model advances after posedge, outputs settle by next negedge.
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] din);
    int sz;
    logic dw, dr;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.data_in = din;
    @(posedge clk);
    sz = mq.size();
    dw = wr && sz < D;
    dr = rd && sz > 0;
    if (dr) m_dout = mq.pop_front();
    if (dw) mq.push_back(din);
    m_ack = dw;
    m_ovf = wr && !dw;
    m_udf = rd && !dr;
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    chk("data_out", 32'(bus.data_out), 32'(m_dout));
    chk("wr_ack", 32'(bus.wr_ack), 32'(m_ack));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
    chk("full", 32'(bus.full), 32'(mq.size() == D));
    chk("almostfull", 32'(bus.almostfull), 32'(mq.size() == D - 1));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("almostempty", 32'(bus.almostempty), 32'(mq.size() == 1));
  end
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_dout", 32'(bus.data_out), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= D; i++) begin
      step(1'b1, 1'b0, W'(i));
      chk("fill_ack", 32'(bus.wr_ack), 32'd1);
      if (i == D - 1) chk("fill_afull", 32'(bus.almostfull), 32'd1);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    step(1'b1, 1'b0, 16'hDEAD);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_noack", 32'(bus.wr_ack), 32'd0);
    chk("ovf_full", 32'(bus.full), 32'd1);
    step(1'b1, 1'b1, 16'h0009);
    chk("fullrw_ovf", 32'(bus.overflow), 32'd1);
    chk("fullrw_dout", 32'(bus.data_out), 32'h0001);
    chk("fullrw_afull", 32'(bus.almostfull), 32'd1);
    for (int i = 2; i <= D; i++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_dout", 32'(bus.data_out), 32'(i));
      if (i == D - 1) chk("drain_aempty", 32'(bus.almostempty), 32'd1);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    step(1'b0, 1'b1, '0);
    chk("udf_pulse", 32'(bus.underflow), 32'd1);
    chk("udf_dout", 32'(bus.data_out), 32'h0008);
    step(1'b1, 1'b1, 16'h00AA);
    chk("emptyrw_udf", 32'(bus.underflow), 32'd1);
    chk("emptyrw_aempty", 32'(bus.almostempty), 32'd1);
    chk("emptyrw_dout", 32'(bus.data_out), 32'h0008);
    step(1'b1, 1'b0, 16'h00BB);
    step(1'b1, 1'b0, 16'h00CC);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, W'($urandom));
    chk("simul_count3", 32'(mq.size()), 32'd3);
    chk("simul_notflag", 32'({bus.full, bus.almostfull, bus.empty, bus.almostempty}), 32'd0);
    step(1'b1, 1'b0, 16'h1111);
    step(1'b1, 1'b0, 16'h2222);
    chk("pre_rst_count5", 32'(mq.size()), 32'd5);
    bus.wr_en = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_dout", 32'(bus.data_out), 32'd0);
    chk("arst_pulses", 32'({bus.wr_ack, bus.overflow, bus.underflow}), 32'd0);
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, '0);
    chk("post_rst_read", 32'(bus.data_out), 32'h1234);
    for (int i = 0; i < 10000; i++) begin
      int p;
      p = ((i / 400) % 2) ? 75 : 25;
      step($urandom_range(0, 99) < p, $urandom_range(0, 99) < 100 - p, W'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
